// File: rtl/fpu_add_normalize_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : FPU_192_Package
//  Description : Shared constants and pipeline-stage register types for the
//                post-alignment single-precision adder datapath.
//                Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package FPU_192_Package;

  localparam int EXP_W = 8;   // exponent width
  localparam int MAN_W = 24;  // mantissa width including hidden bit
  localparam int FMT_W = 32;  // packed result width
  localparam int SUM_W = 25;  // mantissa sum with carry bit

  localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;
  localparam logic [FMT_W-1:0] POS_ZERO = 32'h0000_0000;
  localparam logic [FMT_W-1:0] QNAN     = 32'h7FC0_0000;

  // S1: raw mantissa sum plus everything needed downstream
  typedef struct packed {
    logic             enable;
    logic [FMT_W-1:0] special;
    logic [SUM_W-1:0] sum;
    logic [EXP_W-1:0] exp;
    logic             sign;
  } s1_t;

  // S2: normalized mantissa, round bit and 9-bit working exponent
  typedef struct packed {
    logic             enable;
    logic [FMT_W-1:0] special;
    logic [MAN_W-1:0] mant;
    logic             rbit;
    logic [EXP_W:0]   e;
    logic             sign;
    logic             zero;
    logic             uf;
  } s2_t;

  // S3: packed result and status flags
  typedef struct packed {
    logic [FMT_W-1:0] result;
    logic             overflow;
    logic             underflow;
  } s3_t;

endpackage
`default_nettype wire

// File: rtl/fpu_add_normalize_lzc24.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_lzc24
//  Description : Combinational 24-bit leading-zero counter.
//                din   in  24  value to scan
//                count out  5  number of leading zeros (24 when din == 0)
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_lzc24 (
  input  logic [23:0] din,
  output logic [4:0]  count
);

  // Scanning upward lets the highest set bit make the final assignment.
  always_comb begin
    count = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (din[i]) count = 5'(23 - i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_add_normalize.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_add_normalize
//  Description : Post-alignment FP adder datapath: mantissa add/subtract,
//                leading-zero normalization, round-to-nearest-even on the
//                single shifted-out bit, and IEEE-754 packing. Three-stage
//                valid/ready pipeline with full throughput.
//                clk, rst                 clock, synchronous active-high reset
//                in_valid / in_ready      upstream handshake
//                enable, special_result   arithmetic select / bypass value
//                exp, man_x, man_y        common exponent, aligned mantissas
//                sign, sign_x, sign_y     result sign, effective operand signs
//                out_valid / out_ready    downstream handshake
//                result, overflow, underflow  packed result and flags
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_add_normalize
  import FPU_192_Package::*;
#(
  parameter int EXPONENT_LENGTH           = 8,
  parameter int NORMALIZE_MANTISSA_LENGTH = 24,
  parameter int FORMAT_LENGTH             = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 enable,
  input  logic [FORMAT_LENGTH-1:0]             special_result,
  input  logic [EXPONENT_LENGTH-1:0]           exp,
  input  logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_x,
  input  logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_y,
  input  logic                                 sign,
  input  logic                                 sign_x,
  input  logic                                 sign_y,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [FORMAT_LENGTH-1:0]             result,
  output logic                                 overflow,
  output logic                                 underflow
);

  s1_t        s1_q, s1_d;
  s2_t        s2_q, s2_d;
  s3_t        s3_d;
  logic       s1_valid, s2_valid;
  logic       s1_adv, s2_adv, s3_adv;
  logic [4:0] lz;

  // Each stage may load when its own slot is empty or being drained.
  assign s3_adv   = !out_valid | out_ready;
  assign s2_adv   = !s2_valid  | s3_adv;
  assign s1_adv   = !s1_valid  | s2_adv;
  assign in_ready = s1_adv;

  // ---------------- S1: add / subtract ----------------
  // man_x >= man_y upstream, so the difference never goes negative.
  always_comb begin
    s1_d         = '0;
    s1_d.enable  = enable;
    s1_d.special = special_result;
    s1_d.exp     = exp;
    s1_d.sign    = sign;
    s1_d.sum     = (sign_x ^ sign_y) ? ({1'b0, man_x} - {1'b0, man_y})
                                     : ({1'b0, man_x} + {1'b0, man_y});
  end

  // ---------------- S2: normalize ----------------
  fpu_lzc24 u_lzc (
    .din   (s1_q.sum[23:0]),
    .count (lz)
  );

  always_comb begin
    s2_d         = '0;
    s2_d.enable  = s1_q.enable;
    s2_d.special = s1_q.special;
    s2_d.sign    = s1_q.sign;
    if (s1_q.sum[24]) begin
      s2_d.mant = s1_q.sum[24:1];
      s2_d.rbit = s1_q.sum[0];
      s2_d.e    = {1'b0, s1_q.exp} + 9'd1;
    end else if (s1_q.sum == '0) begin
      s2_d.zero = 1'b1;
    end else if ({3'b000, lz} < s1_q.exp) begin
      s2_d.mant = s1_q.sum[23:0] << lz;
      s2_d.e    = {1'b0, s1_q.exp} - {4'b0000, lz};
    end else begin
      // Would need a subnormal: flush instead.
      s2_d.uf = 1'b1;
    end
  end

  // ---------------- S3: round and pack ----------------
  logic        rnd_inc;
  logic        rnd_carry;
  logic [22:0] frac_r;
  logic [9:0]  e_r;

  // Only the fraction is kept; an all-ones mantissa that rounds up wraps
  // the fraction to zero, which is exactly the 0x800000 renormalization.
  assign rnd_inc   = s2_q.rbit & s2_q.mant[0];
  assign rnd_carry = rnd_inc & (&s2_q.mant);
  assign frac_r    = s2_q.mant[22:0] + {22'd0, rnd_inc};
  assign e_r       = {1'b0, s2_q.e} + {9'd0, rnd_carry};

  always_comb begin
    s3_d = '0;
    if (!s2_q.enable) begin
      s3_d.result = s2_q.special;
    end else if (s2_q.zero || s2_q.uf) begin
      s3_d.result    = POS_ZERO;
      s3_d.underflow = s2_q.uf;
    end else if (e_r >= {2'b00, EXP_MAX}) begin
      s3_d.result   = {s2_q.sign, EXP_MAX, 23'd0};
      s3_d.overflow = 1'b1;
    end else begin
      s3_d.result = {s2_q.sign, e_r[7:0], frac_r};
    end
  end

  // ---------------- stage registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_q <= s2_d;
      end
      if (s3_adv) begin
        out_valid <= s2_valid;
        if (s2_valid) begin
          result    <= s3_d.result;
          overflow  <= s3_d.overflow;
          underflow <= s3_d.underflow;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_add_normalize.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu_add_normalize
//  Description : Self-checking bench for fpu_add_normalize: directed vectors,
//                latency, full-pipeline backpressure, mid-stream reset and a
//                randomized stream against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_add_normalize;
  import FPU_192_Package::*;

  typedef struct {
    logic        en;
    logic [31:0] sp;
    logic [7:0]  ex;
    logic [23:0] mx;
    logic [23:0] my;
    logic        sg;
    logic        sx;
    logic        sy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        enable = 1'b0;
  logic [31:0] special_result = '0;
  logic [7:0]  exp = '0;
  logic [23:0] man_x = '0;
  logic [23:0] man_y = '0;
  logic        sign = 1'b0, sign_x = 1'b0, sign_y = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        overflow, underflow;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          ready_mode = 0;  // 0: always ready, 1: stalled, 2: random
  logic [33:0] cur_exp = '0;
  logic [33:0] expq[$];
  logic        hold_chk = 1'b0;
  logic [33:0] held = '0;

  fpu_add_normalize dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .enable         (enable),
    .special_result (special_result),
    .exp            (exp),
    .man_x          (man_x),
    .man_y          (man_y),
    .sign           (sign),
    .sign_x         (sign_x),
    .sign_y         (sign_y),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  // Reference: integer arithmetic on the specified rules, returns {result, ovf, unf}.
  function automatic logic [33:0] model(input vec_t v);
    int s, e, m, r;
    logic [31:0] ev, mv;
    if (!v.en) return {v.sp, 2'b00};
    s = (v.sx ^ v.sy) ? int'(v.mx) - int'(v.my) : int'(v.mx) + int'(v.my);
    if (s == 0) return {32'h0, 2'b00};
    e = int'(v.ex);
    r = 0;
    m = s;
    if (s >= 32'h100_0000) begin
      r = s % 2;
      m = s / 2;
      e = e + 1;
    end else begin
      while (m < 32'h80_0000) begin
        m = m * 2;
        e = e - 1;
      end
    end
    if (e <= 0) return {32'h0, 2'b01};
    if (r == 1 && (m % 2) == 1) m = m + 1;
    if (m == 32'h100_0000) begin
      m = 32'h80_0000;
      e = e + 1;
    end
    if (e >= 255) return {v.sg, 8'hFF, 23'h0, 2'b10};
    ev = e;
    mv = m;
    return {v.sg, ev[7:0], mv[22:0], 2'b00};
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    logic [31:0] t;
    t     = $urandom;
    v.en  = (t[3:0] != 4'd0);
    v.sg  = t[4];
    v.sx  = t[5];
    v.sy  = t[6];
    v.ex  = (t[9:7] == 3'd0) ? 8'(254 - t[11:10]) :
            (t[9:7] == 3'd1) ? 8'(1 + t[11:10]) : 8'($urandom_range(1, 254));
    t     = $urandom;
    v.mx  = t[31] ? (24'h80_0000 | t[23:0]) : t[23:0];
    t     = $urandom;
    v.my  = t[31] ? (v.mx >> t[4:0]) : 24'(t % (32'(v.mx) + 32'd1));
    v.sp  = $urandom;
    return v;
  endfunction

  function automatic vec_t mk(input logic [7:0] ex, input logic [23:0] mx, input logic [23:0] my,
                              input logic sy);
    vec_t v;
    v.en = 1'b1; v.sp = 32'h1234_5678; v.ex = ex; v.mx = mx; v.my = my;
    v.sg = 1'b0; v.sx = 1'b0; v.sy = sy;
    return v;
  endfunction

  task automatic apply(input vec_t v, input logic [33:0] expv);
    enable = v.en; special_result = v.sp; exp = v.ex; man_x = v.mx; man_y = v.my;
    sign = v.sg; sign_x = v.sx; sign_y = v.sy;
    cur_exp = expv;
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input vec_t v, input logic [33:0] expv);
    logic got;
    int   k;
    apply(v, expv);
    in_valid = 1'b1;
    got = 1'b0;
    k = 0;
    while (!got && k < 200) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!got) chk("accept_timeout", 34'(in_ready), 34'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (expq.size() != 0 && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("drain_left", 34'(expq.size()), 34'd0);
  endtask

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Scoreboard: sample away from the active edge, predict the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) chk("hold_stable", {result, overflow, underflow}, held);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("spurious_out", 34'(out_valid), 34'd0);
        else                  chk("result", {result, overflow, underflow}, expq.pop_front());
      end
      if (in_valid && in_ready) expq.push_back(cur_exp);
      hold_chk = out_valid && !out_ready;
      held     = {result, overflow, underflow};
    end
  end

  initial begin
    vec_t v;
    vec_t dv[$];
    logic [33:0] de[$];
    int   k, acc, idx;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 34'(out_valid), 34'd0);
    chk("rst_result", {result, overflow, underflow}, 34'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 34'(in_ready), 34'd1);
    @(posedge clk);
    #1;

    // Directed vectors with hand-derived results
    dv.push_back(mk(8'h7E, 24'h800000, 24'h580000, 1'b0)); de.push_back({32'h3F580000, 2'b00});
    dv.push_back(mk(8'h7E, 24'h800000, 24'h580000, 1'b1)); de.push_back({32'h3E200000, 2'b00});
    dv.push_back(mk(8'h7E, 24'h800000, 24'h800000, 1'b1)); de.push_back({32'h00000000, 2'b00});
    dv.push_back(mk(8'h80, 24'hC00003, 24'h400000, 1'b0)); de.push_back({32'h40800002, 2'b00});
    dv.push_back(mk(8'h80, 24'hC00001, 24'h400000, 1'b0)); de.push_back({32'h40800000, 2'b00});
    dv.push_back(mk(8'hFE, 24'h800000, 24'h800000, 1'b0)); de.push_back({32'h7F800000, 2'b10});
    dv.push_back(mk(8'h01, 24'h800000, 24'h7FFFFF, 1'b1)); de.push_back({32'h00000000, 2'b01});
    dv.push_back(mk(8'h03, 24'h800000, 24'h580000, 1'b1)); de.push_back({32'h00A00000, 2'b00});
    dv.push_back(mk(8'h02, 24'h800000, 24'h580000, 1'b1)); de.push_back({32'h00000000, 2'b01});
    dv.push_back(mk(8'h80, 24'hFFFFFF, 24'h800000, 1'b0)); de.push_back({32'h40C00000, 2'b00});
    v = mk(8'h55, 24'hABCDEF, 24'h123456, 1'b1);
    v.en = 1'b0; v.sp = QNAN;
    dv.push_back(v); de.push_back({32'h7FC00000, 2'b00});
    foreach (dv[i]) send(dv[i], de[i]);
    drain();

    // Latency of a lone bypass bundle
    apply(v, {QNAN, 2'b00});
    in_valid = 1'b1;
    @(negedge clk);
    chk("lat_in_ready", 34'(in_ready), 34'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 10) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("latency", 34'(k), 34'd3);
    drain();

    // Full pipeline: six bundles against a stalled consumer
    for (int i = 0; i < 6; i++) begin
      v = rand_vec();
      v.en = 1'b1;
      dv[i] = v;
      de[i] = model(v);
    end
    ready_mode = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    acc = 0;
    idx = 0;
    apply(dv[0], de[0]);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      logic got;
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) begin
        acc++;
        idx++;
        apply(dv[idx], de[idx]);
      end
    end
    in_valid = 1'b0;
    chk("full_accepts", 34'(acc), 34'd3);
    chk("full_in_ready", 34'(in_ready), 34'd0);
    ready_mode = 0;
    for (int i = idx; i < 6; i++) send(dv[i], de[i]);
    drain();

    // Reset with bundles in flight
    for (int i = 0; i < 4; i++) begin
      v = rand_vec();
      send(v, model(v));
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    expq.delete();
    chk("midrst_out_valid", 34'(out_valid), 34'd0);
    chk("midrst_result", {result, overflow, underflow}, 34'd0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready", 34'(in_ready), 34'd1);
    repeat (8) @(posedge clk);
    #1;

    // Randomized stream with random backpressure
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      v = rand_vec();
      send(v, model(v));
    end
    ready_mode = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_add_normalize.md
# fpu_add_normalize

Post-alignment datapath of the single-precision FP adder. Sits directly downstream of `Pre_Normalization` and consumes its special/normal flag, common exponent, swapped-and-aligned mantissas and signs. Performs the mantissa add/subtract, leading-zero normalization, round-to-nearest-even on the shifted-out bit, and IEEE-754 packing. It is a 3-stage valid/ready pipeline with full throughput and backpressure.

## Interface
Parameters:
- `EXPONENT_LENGTH`, 8, exponent width
- `NORMALIZE_MANTISSA_LENGTH`, 24, mantissa width including the hidden bit
- `FORMAT_LENGTH`, 32, packed result width

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `in_valid`  in  1  the upstream bundle below is valid.
- `in_ready`  out  1  this block accepts the bundle this cycle.
- `enable`  in  1  1 selects the normal arithmetic path; 0 selects bypass of `special_result`.
- `special_result`  in  32  precomputed ZERO/NAN/INFINITY result.
- `exp`  in  8  common (larger) exponent.
- `man_x`  in  24  larger-magnitude mantissa.
- `man_y`  in  24  smaller mantissa, already right-aligned.
- `sign`  in  1  result sign.
- `sign_x`, `sign_y`  in  1 each  effective operand signs.
- `out_valid`  out  1  `result` and the flags are valid.
- `out_ready`  in  1  the downstream consumer accepts.
- `result`  out  32  packed single-precision result.
- `overflow`  out  1  result saturated to infinity.
- `underflow`  out  1  result flushed to zero.

## Operation
- Effective subtract: `eff_sub = sign_x ^ sign_y`. Because `man_x >= man_y`, the difference is never negative.
- S1 (stage 1):
  - `sum[24:0] = eff_sub ? man_x - man_y : man_x + man_y`.
  - Registers `sum`, `exp`, `sign`, `enable`, `special_result`.
- S2 (stage 2):
  - If `sum[24]`: `mant = sum[24:1]`, `rbit = sum[0]`, `e = exp + 1`.
  - Else if `sum == 0`: exact zero. Result is `+0`, `underflow = 0`.
  - Else: `lz = lzc(sum[23:0])`.
    - If `exp > lz`: `mant = sum[23:0] << lz`, `e = exp - lz`, `rbit = 0`.
    - Else: flush to `+0` and set `underflow = 1`. No subnormals are produced.
  - `e` is held 9 bits wide.
- S3 (stage 3):
  - Round-to-nearest-even: increment `mant` iff `rbit & mant[0]`. A single shifted-out bit is always an exact tie.
  - If the increment carries out, set `mant = 24'h800000` and `e = e + 1`.
  - If `e >= 255`: `result = {sign, 8'hFF, 23'h0}`, `overflow = 1`.
  - Else: `result = {sign, e[7:0], mant[22:0]}`.
- Bypass (`enable = 0`): `special_result` travels through all three stages unchanged. Arithmetic is ignored and both flags are 0.
- Ordering: in-order and lossless. No bundle is dropped or duplicated.

## Timing
- Handshake:
  - A transfer occurs when `valid & ready` on a rising edge.
  - `out_valid`, `result` and the flags hold stable while `out_valid & !out_ready`.
- Pipeline advance:
  - `stage_k` advances when `!valid_(k+1) | advance_(k+1)`.
  - `in_ready = !s1_valid | s1_advance`, combinational from `out_ready`.
- Latency: 3 cycles from input handshake to `out_valid` when not stalled. Throughput is 1 result per cycle.
- Full pipeline: with `out_ready` held low, at most 3 bundles are accepted, then `in_ready = 0`.
- Simultaneous accept and drain in the same cycle is legal in every stage.
- Reset values:
  - All stage valids = 0 and `out_valid = 0`.
  - `result = 32'h0`, `overflow = 0`, `underflow = 0`.
  - `in_ready = 1` in the cycle after `rst` deasserts.
- Reset mid-operation discards all in-flight bundles. `rst` has priority over every handshake.

## Structure
- Shared package `FPU_192_Package` holds:
  - width constants;
  - `EXP_MAX = 8'hFF`;
  - `POS_ZERO = 32'h0`;
  - `QNAN = 32'h7FC00000`;
  - a typedef per stage register struct (`s1_t`, `s2_t`, `s3_t`).
- Sub-module `fpu_lzc24`: combinational 24-bit leading-zero counter. Output is 5 bits; an all-zero input returns 24.
- Top level: three stage registers with their valid/advance logic, plus the S1/S2/S3 datapath.

## Test plan
- Add: `exp=7E`, `man_x=800000`, `man_y=580000`, signs 0 -> `result=3F580000` exactly 3 cycles after accept, both flags 0.
- Subtract: same operands with `sign_y=1` -> `lz=2`, `result=3E200000`. Cancellation with `man_x=man_y=800000` -> `result=00000000`, `underflow=0`.
- Carry and RNE:
  - `exp=80`, `man_x=C00003`, `man_y=400000` -> `result=40800002` (rounds up to even).
  - `man_x=C00001`, `man_y=400000` -> `result=40800000` (no increment).
- Overflow: `exp=FE`, `man_x=man_y=800000`, add -> `result=7F800000`, `overflow=1`. Underflow: `exp=01`, `man_x=800000`, `man_y=7FFFFF`, subtract -> `result=0`, `underflow=1`.
- Bypass: `enable=0`, `special_result=7FC00000` with garbage mantissas -> `result=7FC00000`, flags 0, 3-cycle latency.
- Backpressure and reset:
  - Stream 6 bundles with `out_ready` low for 5 cycles -> `in_ready` falls after 3 accepts. All 6 results then emerge in order with no loss.
  - Asserting `rst` mid-stream -> `out_valid=0` next cycle and no stale result appears.
